// File: rtl/freq_bcd_convert.sv
// Binary-to-BCD converter for the frequency meter display: iterative double-dabble engine,
// leading-zero blanking mask and a hold timer that rate-limits display updates.
module freq_bcd_convert #(
    parameter int unsigned DATA_W      = 20,
    parameter int unsigned DIGITS      = 7,
    parameter int unsigned HOLD_CYCLES = 25_000_000
) (
    input  logic                  clk_fs,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     data_fx,
    output logic [4*DIGITS-1:0]   bcd_data,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  bcd_valid,
    output logic                  busy
);

    localparam int unsigned BcdW  = 4 * DIGITS;
    localparam int unsigned CntW  = $clog2(DATA_W + 1);
    localparam int unsigned HoldW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   bin_sr_q, bin_sr_d;
    logic [BcdW-1:0]     bcd_acc_q, bcd_acc_d;
    logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   last_val_q, last_val_d;
    logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [BcdW-1:0]     bcd_data_q, bcd_data_d;
    logic [DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                bcd_valid_q, bcd_valid_d;

    logic [BcdW-1:0]     acc_adj;
    logic [DIGITS-1:0]   en_new;
    logic                lit_above;

    // Add-3 correction on every digit before the shift.
    always_comb begin
        acc_adj = bcd_acc_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (bcd_acc_q[4*k +: 4] >= 4'd5) begin
                acc_adj[4*k +: 4] = bcd_acc_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // A digit is lit if it or any more significant digit is nonzero; units always lit.
    always_comb begin
        en_new    = '0;
        lit_above = 1'b0;
        for (int k = int'(DIGITS) - 1; k > 0; k--) begin
            lit_above = lit_above | (|bcd_acc_q[4*k +: 4]);
            en_new[k] = lit_above;
        end
        en_new[0] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        bin_sr_d    = bin_sr_q;
        bcd_acc_d   = bcd_acc_q;
        bit_cnt_d   = bit_cnt_q;
        last_val_d  = last_val_q;
        bcd_data_d  = bcd_data_q;
        digit_en_d  = digit_en_q;
        bcd_valid_d = 1'b0;
        hold_cnt_d  = (hold_cnt_q != '0) ? hold_cnt_q - HoldW'(1) : '0;

        unique case (state_q)
            StIdle: begin
                if ((data_fx != last_val_q) && (hold_cnt_q == '0)) begin
                    bin_sr_d   = data_fx;
                    last_val_d = data_fx;
                    bcd_acc_d  = '0;
                    bit_cnt_d  = '0;
                    state_d    = StShift;
                end
            end
            StShift: begin
                bcd_acc_d = {acc_adj[BcdW-2:0], bin_sr_q[DATA_W-1]};
                bin_sr_d  = {bin_sr_q[DATA_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + CntW'(1);
                if (bit_cnt_q == CntW'(DATA_W - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bcd_data_d  = bcd_acc_q;
                digit_en_d  = en_new;
                bcd_valid_d = 1'b1;
                hold_cnt_d  = HoldW'(HOLD_CYCLES);
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bin_sr_q    <= '0;
            bcd_acc_q   <= '0;
            bit_cnt_q   <= '0;
            last_val_q  <= '0;
            hold_cnt_q  <= '0;
            bcd_data_q  <= '0;
            digit_en_q  <= DIGITS'(1);
            bcd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_sr_q    <= bin_sr_d;
            bcd_acc_q   <= bcd_acc_d;
            bit_cnt_q   <= bit_cnt_d;
            last_val_q  <= last_val_d;
            hold_cnt_q  <= hold_cnt_d;
            bcd_data_q  <= bcd_data_d;
            digit_en_q  <= digit_en_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    assign bcd_data  = bcd_data_q;
    assign digit_en  = digit_en_q;
    assign bcd_valid = bcd_valid_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_freq_bcd_convert.sv
// Self-checking bench for freq_bcd_convert: directed spec cases plus randomized values
// checked against an arithmetic decimal-digit model.
module tb_freq_bcd_convert;

    localparam int unsigned DW   = 20;
    localparam int unsigned DG   = 7;
    localparam int unsigned HOLD = 100;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DW-1:0]     data_fx, data_h;
    logic [4*DG-1:0]   bcd_data, bcd_data_h;
    logic [DG-1:0]     digit_en, digit_en_h;
    logic              bcd_valid, bcd_valid_h, busy, busy_h;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] last_applied = '0;

    always #5 clk = ~clk;

    freq_bcd_convert #(.DATA_W(DW), .DIGITS(DG), .HOLD_CYCLES(0)) dut (
        .clk_fs(clk), .rst_n(rst_n), .data_fx(data_fx), .bcd_data(bcd_data),
        .digit_en(digit_en), .bcd_valid(bcd_valid), .busy(busy)
    );

    freq_bcd_convert #(.DATA_W(DW), .DIGITS(DG), .HOLD_CYCLES(HOLD)) dut_h (
        .clk_fs(clk), .rst_n(rst_n), .data_fx(data_h), .bcd_data(bcd_data_h),
        .digit_en(digit_en_h), .bcd_valid(bcd_valid_h), .busy(busy_h)
    );

    function automatic logic [4*DG-1:0] ref_bcd(input longint unsigned v);
        logic [4*DG-1:0] r = '0;
        longint unsigned p = 1;
        for (int k = 0; k < int'(DG); k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [DG-1:0] ref_en(input longint unsigned v);
        logic [DG-1:0] r = '0;
        longint unsigned p = 1;
        for (int k = 0; k < int'(DG); k++) begin
            r[k] = (k == 0) || (v >= p);
            p = p * 10;
        end
        return r;
    endfunction

    // Samples dut for n falling edges; optionally changes data_fx at falling edge chg_at.
    task automatic observe(input int n, input int chg_at, input logic [DW-1:0] chg_val,
                           output int nv, output int nb, output int v1_i,
                           output logic [4*DG-1:0] v1_b, output logic [DG-1:0] v1_e,
                           output int v2_i, output logic [4*DG-1:0] v2_b);
        nv = 0; nb = 0; v1_i = -1; v2_i = -1; v1_b = '0; v1_e = '0; v2_b = '0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (bcd_valid) begin
                nv++;
                if (nv == 1) begin
                    v1_i = i; v1_b = bcd_data; v1_e = digit_en;
                end else if (nv == 2) begin
                    v2_i = i; v2_b = bcd_data;
                end
            end
            if (i == chg_at) data_fx = chg_val;
        end
    endtask

    task automatic test_reset();
        int nv, nb, v1_i, v2_i;
        logic [4*DG-1:0] v1_b, v2_b;
        logic [DG-1:0] v1_e;
        rst_n = 1'b0; data_fx = '0; data_h = '0;
        repeat (3) @(negedge clk);
        checks++; if (bcd_data !== '0) begin errors++;
            $display("FAIL reset_bcd: got %h expected 0", bcd_data); end
        checks++; if (digit_en !== 7'b0000001) begin errors++;
            $display("FAIL reset_en: got %b expected 0000001", digit_en); end
        checks++; if (bcd_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL reset_flags: got valid=%b busy=%b expected 0 0", bcd_valid, busy); end
        rst_n = 1'b1;
        observe(100, 0, '0, nv, nb, v1_i, v1_b, v1_e, v2_i, v2_b);
        checks++; if (nv != 0 || nb != 0) begin errors++;
            $display("FAIL reset_idle: got pulses=%0d busy=%0d expected 0 0", nv, nb); end
    endtask

    task automatic test_conversion();
        logic [DW-1:0]   vals [3] = '{20'd1_000_000, 20'hFFFFF, 20'd7};
        logic [4*DG-1:0] expb [3] = '{28'h1000000, 28'h1048575, 28'h0000007};
        logic [DG-1:0]   expe [3] = '{7'h7F, 7'h7F, 7'h01};
        int nv, nb, v1_i, v2_i;
        logic [4*DG-1:0] v1_b, v2_b;
        logic [DG-1:0] v1_e;
        for (int t = 0; t < 3; t++) begin
            data_fx = vals[t]; last_applied = vals[t];
            observe(30, 0, '0, nv, nb, v1_i, v1_b, v1_e, v2_i, v2_b);
            checks++; if (v1_i != 22 || nv != 1) begin errors++;
                $display("FAIL conv_timing[%0d]: got pulse at %0d count %0d expected 22 1",
                         t, v1_i, nv); end
            checks++; if (nb != 21) begin errors++;
                $display("FAIL conv_busy[%0d]: got %0d cycles expected 21", t, nb); end
            checks++; if (v1_b !== expb[t] || v1_e !== expe[t]) begin errors++;
                $display("FAIL conv_value[%0d]: got %h/%h expected %h/%h",
                         t, v1_b, v1_e, expb[t], expe[t]); end
            checks++; if (bcd_data !== expb[t]) begin errors++;
                $display("FAIL conv_hold[%0d]: got %h expected %h", t, bcd_data, expb[t]); end
        end
    endtask

    task automatic test_back_to_back();
        int nv, nb, v1_i, v2_i;
        logic [4*DG-1:0] v1_b, v2_b;
        logic [DG-1:0] v1_e;
        data_fx = 20'd123;
        observe(60, 5, 20'd456, nv, nb, v1_i, v1_b, v1_e, v2_i, v2_b);
        last_applied = 20'd456;
        checks++; if (v1_i != 22 || v1_b !== 28'h0000123 || v1_e !== 7'h07) begin errors++;
            $display("FAIL b2b_first: got @%0d %h/%h expected @22 0000123/07", v1_i, v1_b, v1_e); end
        checks++; if (v2_i != 44 || v2_b !== 28'h0000456 || nv != 2) begin errors++;
            $display("FAIL b2b_second: got @%0d %h n=%0d expected @44 0000456 n=2",
                     v2_i, v2_b, nv); end
    endtask

    task automatic test_hold();
        int p1 = -1, first_busy = -1, p2 = -1;
        logic [4*DG-1:0] b1 = '0, b2 = '0;
        data_h = 20'd4321;
        for (int i = 1; i <= 40 && p1 < 0; i++) begin
            @(negedge clk);
            if (bcd_valid_h) begin p1 = i; b1 = bcd_data_h; end
        end
        checks++; if (p1 != 22 || b1 !== ref_bcd(4321)) begin errors++;
            $display("FAIL hold_first: got @%0d %h expected @22 %h", p1, b1, ref_bcd(4321)); end
        // Counter loads HOLD at DONE and needs HOLD more edges to reach 0; the load edge follows.
        for (int k = 1; k <= 300 && p2 < 0; k++) begin
            @(negedge clk);
            if (k == 2) data_h = 20'd8765;
            if (busy_h && first_busy < 0) first_busy = k;
            if (bcd_valid_h) begin p2 = k; b2 = bcd_data_h; end
        end
        checks++; if (first_busy != int'(HOLD) + 1) begin errors++;
            $display("FAIL hold_gap: got load at %0d expected %0d", first_busy, HOLD + 1); end
        checks++; if (b2 !== ref_bcd(8765) || p2 != int'(HOLD) + 22) begin errors++;
            $display("FAIL hold_second: got @%0d %h expected @%0d %h",
                     p2, b2, HOLD + 22, ref_bcd(8765)); end
    endtask

    task automatic test_abort();
        int nv, nb, v1_i, v2_i;
        logic [4*DG-1:0] v1_b, v2_b;
        logic [DG-1:0] v1_e;
        data_fx = 20'd999_999;
        observe(8, 0, '0, nv, nb, v1_i, v1_b, v1_e, v2_i, v2_b);
        rst_n = 1'b0;
        #1;
        checks++; if (bcd_data !== '0 || digit_en !== 7'h01) begin errors++;
            $display("FAIL abort_out: got %h/%h expected 0000000/01", bcd_data, digit_en); end
        checks++; if (busy !== 1'b0 || bcd_valid !== 1'b0 || nv != 0) begin errors++;
            $display("FAIL abort_flags: got busy=%b valid=%b pulses=%0d expected 0 0 0",
                     busy, bcd_valid, nv); end
        data_fx = 20'd50;
        repeat (2) @(negedge clk);
        checks++; if (bcd_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL abort_held: got valid=%b busy=%b expected 0 0", bcd_valid, busy); end
        rst_n = 1'b1; last_applied = 20'd50;
        observe(30, 0, '0, nv, nb, v1_i, v1_b, v1_e, v2_i, v2_b);
        checks++; if (v1_i != 22 || v1_b !== 28'h0000050 || v1_e !== 7'h03 || nv != 1) begin
            errors++;
            $display("FAIL abort_after: got @%0d %h/%h n=%0d expected @22 0000050/03 n=1",
                     v1_i, v1_b, v1_e, nv); end
    endtask

    task automatic test_random();
        logic [DW-1:0] dir [6] = '{20'd0, 20'd9, 20'd10, 20'd99_999, 20'd100_000, 20'd999_999};
        logic [DW-1:0] v;
        int nv, nb, v1_i, v2_i;
        logic [4*DG-1:0] v1_b, v2_b;
        logic [DG-1:0] v1_e;
        for (int t = 0; t < 26; t++) begin
            if (t < 6) v = dir[t];
            else if ($urandom_range(0, 1) == 1) v = DW'($urandom_range(0, 999));
            else v = DW'($urandom_range(0, 20'hFFFFF));
            if (v == last_applied) v = v ^ 20'd1;
            data_fx = v; last_applied = v;
            observe(25, 0, '0, nv, nb, v1_i, v1_b, v1_e, v2_i, v2_b);
            checks++;
            if (v1_i != 22 || nv != 1 || v1_b !== ref_bcd(v) || v1_e !== ref_en(v)) begin
                errors++;
                $display("FAIL rand[%0d] v=%0d: got @%0d n=%0d %h/%h expected @22 n=1 %h/%h",
                         t, v, v1_i, nv, v1_b, v1_e, ref_bcd(v), ref_en(v));
            end
        end
    endtask

    task automatic test_no_change();
        int nv, nb, v1_i, v2_i;
        logic [4*DG-1:0] v1_b, v2_b;
        logic [DG-1:0] v1_e;
        data_fx = last_applied;
        observe(40, 0, '0, nv, nb, v1_i, v1_b, v1_e, v2_i, v2_b);
        checks++; if (nv != 0 || nb != 0) begin errors++;
            $display("FAIL no_change: got pulses=%0d busy=%0d expected 0 0", nv, nb); end
        checks++; if (bcd_data !== ref_bcd(last_applied)) begin errors++;
            $display("FAIL no_change_hold: got %h expected %h", bcd_data,
                     ref_bcd(last_applied)); end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_conversion();
        test_back_to_back();
        test_hold();
        test_abort();
        test_random();
        test_no_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
